// File: rtl/sdram_arbiter.sv
// sdram_arbiter: time-slot arbiter that shares the SDRAM controller's CPU port
// between requester A (CPU) and requester B (ROM loader).
// Each frame is 2*SLOTS clocks: a video cycle (p = 0..SLOTS-1) followed by a
// shared cycle (p = SLOTS..2*SLOTS-1). At most one access is granted per frame.
// Ports:
//   clk, reset_n             system clock, synchronous active-low reset
//   sdram_ready              controller initialisation complete
//   sync                     frame sync, high while p == 2*SLOTS-1
//   sd_adr/sd_we/sd_di/sd_do controller CPU port (address, write, data in/out)
//   a_* / b_*                requester request, write flag, address, data, ack
//   gnt                      current owner: 01 = A, 10 = B, 00 = none
module sdram_arbiter #(
  parameter int unsigned SLOTS = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sdram_ready,
  output logic        sync,
  output logic [24:0] sd_adr,
  output logic        sd_we,
  output logic [7:0]  sd_di,
  input  logic [7:0]  sd_do,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [24:0] a_adr,
  input  logic [7:0]  a_di,
  output logic        a_ack,
  output logic [7:0]  a_do,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [24:0] b_adr,
  input  logic [7:0]  b_di,
  output logic        b_ack,
  output logic [7:0]  b_do,
  output logic [1:0]  gnt
);

  localparam int unsigned PW = $clog2(2 * SLOTS);
  localparam int unsigned AW = 25;
  localparam int unsigned DW = 8;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A    = 2'b01;
  localparam logic [1:0] GNT_B    = 2'b10;

  logic [PW-1:0] p, p_nxt;
  logic          sync_nxt;
  logic [1:0]    gnt_nxt;
  logic          last_b, last_b_nxt;   // 1 = B was served last
  logic [AW-1:0] sd_adr_nxt;
  logic          sd_we_nxt;
  logic [DW-1:0] sd_di_nxt;
  logic          a_ack_nxt, b_ack_nxt;
  logic [DW-1:0] a_do_nxt, b_do_nxt;
  logic          decide, done, a_el, b_el, pick_a, pick_b;

  // Next-state logic: phase counter, grant decision and completion.
  always_comb begin
    p_nxt      = (p == PW'(2 * SLOTS - 1)) ? '0 : p + PW'(1);
    sync_nxt   = (p == PW'(2 * SLOTS - 2));
    gnt_nxt    = gnt;
    last_b_nxt = last_b;
    sd_adr_nxt = sd_adr;
    sd_we_nxt  = sd_we;
    sd_di_nxt  = sd_di;
    a_ack_nxt  = 1'b0;
    b_ack_nxt  = 1'b0;
    a_do_nxt   = a_do;
    b_do_nxt   = b_do;

    decide = (p == PW'(SLOTS - 1));
    done   = (p == PW'(SLOTS + 6));
    a_el   = sdram_ready & a_req;
    b_el   = sdram_ready & b_req;
    // Round-robin: on contention the requester not served last wins.
    pick_a = a_el & (~b_el | last_b);
    pick_b = b_el & ~pick_a;

    if (decide) begin
      if (pick_a) begin
        gnt_nxt    = GNT_A;
        last_b_nxt = 1'b0;
        sd_adr_nxt = a_adr;
        sd_we_nxt  = a_we;
        sd_di_nxt  = a_di;
      end else if (pick_b) begin
        gnt_nxt    = GNT_B;
        last_b_nxt = 1'b1;
        sd_adr_nxt = b_adr;
        sd_we_nxt  = b_we;
        sd_di_nxt  = b_di;
      end else begin
        // Idle shared cycle becomes a harmless read of the held address.
        gnt_nxt   = GNT_NONE;
        sd_we_nxt = 1'b0;
      end
    end

    // Completion is keyed on gnt, so an access survives req or ready dropping.
    if (done) begin
      if (gnt == GNT_A) begin
        a_do_nxt  = sd_do;
        a_ack_nxt = 1'b1;
      end else if (gnt == GNT_B) begin
        b_do_nxt  = sd_do;
        b_ack_nxt = 1'b1;
      end
      gnt_nxt = GNT_NONE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p      <= '0;
      sync   <= 1'b0;
      gnt    <= GNT_NONE;
      last_b <= 1'b1;
      sd_adr <= '0;
      sd_we  <= 1'b0;
      sd_di  <= '0;
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      a_do   <= '0;
      b_do   <= '0;
    end else begin
      p      <= p_nxt;
      sync   <= sync_nxt;
      gnt    <= gnt_nxt;
      last_b <= last_b_nxt;
      sd_adr <= sd_adr_nxt;
      sd_we  <= sd_we_nxt;
      sd_di  <= sd_di_nxt;
      a_ack  <= a_ack_nxt;
      b_ack  <= b_ack_nxt;
      a_do   <= a_do_nxt;
      b_do   <= b_do_nxt;
    end
  end

endmodule
